crc_check_ctrl: RTL and testbench
=================================

Name: crc_check_ctrl

Overview:
- Sequences one complete CRC integrity check of the 1024-word data memory.
- Requests the shared memory port and streams every address through the read pipeline into the CRC calculator.
- Compares the final CRC against a reference value and reports pass/fail plus a saturating error count.
- Sits between the system control logic (start/abort/auto-check) and the memory arbiter plus CRC calculation datapath.

Parameters:
- ADDR_W, 10, memory address width; a run covers addresses 0..2^ADDR_W-1.
- DATA_W, 8, memory/CRC input data width.
- CRC_W, 16, CRC result width.
- RD_LAT, 2, memory read latency in cycles (≥1).
- PERIOD, 50000000, auto-check interval in clk50m cycles (≥2).

Ports:
- rst_n  in  1  reset: asynchronous, active-low.
- clk50m  in  1  clock, 50 MHz.
- start  in  1  start a run; sampled in IDLE only.
- abort  in  1  cancel the current run.
- auto_en  in  1  enables the periodic check timer.
- mem_req  out  1  request to the memory arbiter.
- mem_gnt  in  1  arbiter grant; may drop at any cycle.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after the address is issued.
- crc_clr  out  1  clears the CRC calculator (1-cycle pulse).
- crc_en  out  1  CRC calculator consumes crc_data this cycle.
- crc_data  out  DATA_W  equals mem_rdata.
- crc_value  in  CRC_W  registered CRC result, updated on crc_en edges.
- crc_ref  in  CRC_W  expected CRC, static during a run.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse, run finished.
- pass  out  1  last run matched.
- fail  out  1  last run mismatched.
- err_cnt  out  8  number of failed runs, saturates at 255.

Behaviour:
- Reset values: all outputs 0, state IDLE, address counter 0, valid pipeline empty, pending flag 0, timer = PERIOD-1.
- States: IDLE, REQ, READ, DRAIN, CHECK.
- Timer:
  - Decrements every cycle while auto_en=1; reloads PERIOD-1 at 0 or when auto_en=0.
  - Reaching 0 sets pending.
  - pending is cleared when a run starts; at most one pending trigger is held.
- IDLE:
  - If start=1 or pending=1, next state is REQ and crc_clr=1 in that REQ's first cycle.
  - pass and fail clear when REQ is entered.
  - start outside IDLE is ignored; it is not queued.
- REQ:
  - mem_req=1, address counter=0.
  - Moves to READ on the cycle after mem_gnt is sampled 1.
- READ:
  - mem_req=1; mem_addr = counter.
  - A read is issued in any cycle where mem_gnt=1: a 1 enters the RD_LAT-deep valid shift register and the counter increments.
  - With mem_gnt=0, no read is issued, a 0 enters the shift register, and the address holds.
  - After issuing address 2^ADDR_W-1, next state is DRAIN. The counter does not wrap into a new run.
- Output path: crc_en = last valid shift-register stage; crc_data = mem_rdata. Data of already-issued reads is always consumed, even after grant loss.
- DRAIN:
  - mem_req=0.
  - Exits to CHECK when the shift register is all zero, i.e. the cycle after the final crc_en.
- CHECK (one cycle): compares crc_value with crc_ref.
  - On the next edge: done=1 for one cycle, pass=(equal), fail=!(equal).
  - On mismatch, err_cnt increments (saturating at 255).
  - State returns to IDLE.
  - pass and fail hold until the next run starts.
- abort=1 in any non-IDLE state, at the next edge:
  - state goes to IDLE, mem_req=0, shift register flushed, crc_en=0.
  - No done pulse; pass, fail and err_cnt are unchanged.
- Simultaneous events:
  - abort has priority over all transitions.
  - A timer expiry in the same cycle as start is consumed by that run.
- Latency with continuous grant: start at cycle T, then REQ at T+1, first address at T+2, last crc_en at T+1025+RD_LAT, done at T+1027+RD_LAT (T+1029 for RD_LAT=2).
- Asynchronous reset mid-run returns to the reset values immediately; err_cnt clears.

Test Plan:
- Memory filled so the CRC equals crc_ref, gnt tied 1, start pulse at T → 1024 crc_en pulses with addresses 0..1023 in order, done at T+1029, pass=1, fail=0, err_cnt=0.
- Same run with crc_ref off by 1 → done at T+1029, fail=1, err_cnt=1; three more failing runs → err_cnt=4; preload 255 → stays 255.
- gnt toggled 1/0 randomly, 30% low → address never skips or repeats, exactly 1024 crc_en pulses, crc_data matches memory[k] in order, same CRC result as the uninterrupted run.
- abort at address 500 → next cycle busy=0, mem_req=0, crc_en=0, no done; a following start gives a full correct run with pass=1.
- PERIOD=3000, auto_en=1, no start → a run starts at each timer expiry; an expiry during busy starts a new run immediately after done; a start pulse during busy is ignored.
- Reset asserted during READ → all outputs 0 asynchronously; after release, start runs normally.

Source files
------------

// File: rtl/crc_check_ctrl.sv
// crc_check_ctrl: sequences one CRC integrity pass over the data memory.
// Ports: clk50m/rst_n; start/abort/auto_en control; mem_req/mem_gnt/
// mem_addr/mem_rdata memory port; crc_clr/crc_en/crc_data/crc_value/
// crc_ref CRC datapath; busy/done/pass/fail/err_cnt status.
module crc_check_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CRC_W  = 16,
    parameter int RD_LAT = 2,
    parameter int PERIOD = 50000000
) (
    input  logic              rst_n,
    input  logic              clk50m,
    input  logic              start,
    input  logic              abort,
    input  logic              auto_en,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              crc_clr,
    output logic              crc_en,
    output logic [DATA_W-1:0] crc_data,
    input  logic [CRC_W-1:0]  crc_value,
    input  logic [CRC_W-1:0]  crc_ref,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [7:0]        err_cnt
);

    localparam int TW = $clog2(PERIOD);
    localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_DRAIN,
        S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              pend_q, pend_d;
    logic              clr_q, clr_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [7:0]        err_q, err_d;

    logic issue;
    logic expire;
    logic run_start;
    logic kill;
    logic crc_eq;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        clr_d     = 1'b0;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        issue     = 1'b0;
        run_start = 1'b0;
        crc_eq    = (crc_value == crc_ref);
        kill      = abort && (state_q != S_IDLE);

        expire = auto_en && (tmr_q == '0);
        tmr_d  = (!auto_en || tmr_q == '0) ? TMAX : tmr_q - 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start || pend_q) begin
                    state_d   = S_REQ;
                    run_start = 1'b1;
                    clr_d     = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            S_REQ: begin
                addr_d = '0;
                if (mem_gnt) state_d = S_READ;
            end
            S_READ: begin
                if (mem_gnt) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == '1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once only the final stage (or nothing) is valid, so
                // CHECK lands on the cycle after the last crc_en.
                if (RD_LAT'({vld_q, 1'b0}) == '0) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                pass_d  = crc_eq;
                fail_d  = !crc_eq;
                if (!crc_eq && err_q != 8'hff) err_d = err_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // An expiry coinciding with a run start is absorbed by that run.
        pend_d = run_start ? 1'b0 : (pend_q || expire);
        vld_d  = RD_LAT'({vld_q, issue});

        if (kill) begin
            state_d = S_IDLE;
            clr_d   = 1'b0;
            done_d  = 1'b0;
            pass_d  = pass_q;
            fail_d  = fail_q;
            err_d   = err_q;
            vld_d   = '0;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            vld_q   <= '0;
            tmr_q   <= TMAX;
            pend_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign mem_req  = (state_q == S_REQ) || (state_q == S_READ);
    assign mem_addr = addr_q;
    assign crc_clr  = clr_q;
    assign crc_en   = vld_q[RD_LAT-1];
    assign crc_data = mem_rdata;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_crc_check_ctrl.sv
// tb_crc_check_ctrl: scoreboard bench for crc_check_ctrl with a memory,
// a CRC-16 calculator and a run-level reference model.
module tb_crc_check_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int RL  = 2;
    localparam int PER = 3000;
    localparam int N   = 1 << AW;
    localparam int LAT = 1027 + RL;

    logic clk50m = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic auto_en = 1'b0;
    logic mem_gnt = 1'b0;
    logic mem_req, crc_clr, crc_en, busy, done, pass, fail;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, crc_data;
    logic [CW-1:0] crc_value;
    logic [CW-1:0] crc_ref = '0;
    logic [7:0] err_cnt;

    always #10 clk50m = ~clk50m;

    crc_check_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .CRC_W(CW), .RD_LAT(RL), .PERIOD(PER)
    ) dut (
        .rst_n(rst_n), .clk50m(clk50m), .start(start), .abort(abort),
        .auto_en(auto_en), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .crc_clr(crc_clr),
        .crc_en(crc_en), .crc_data(crc_data), .crc_value(crc_value),
        .crc_ref(crc_ref), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .err_cnt(err_cnt)
    );

    // Small always-failing instance used to reach counter saturation.
    logic s_rst_n = 1'b0;
    logic s_start = 1'b0;
    logic s_req, s_clr, s_en, s_busy, s_done, s_pass, s_fail;
    logic [3:0] s_addr;
    logic [7:0] s_data, s_err;

    crc_check_ctrl #(
        .ADDR_W(4), .DATA_W(8), .CRC_W(16), .RD_LAT(1), .PERIOD(2)
    ) u_sat (
        .rst_n(s_rst_n), .clk50m(clk50m), .start(s_start), .abort(1'b0),
        .auto_en(1'b0), .mem_req(s_req), .mem_gnt(1'b1),
        .mem_addr(s_addr), .mem_rdata(8'h00), .crc_clr(s_clr),
        .crc_en(s_en), .crc_data(s_data), .crc_value(16'h0000),
        .crc_ref(16'h0001), .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail(s_fail), .err_cnt(s_err)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Memory with RL-cycle read latency.
    logic [7:0] mem [N];
    logic [7:0] rd_pipe [RL];
    always @(posedge clk50m) begin
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        c = 16'hffff;
        for (int k = 0; k < N; k++) c = crc_step(c, mem[k]);
        return c;
    endfunction

    logic [15:0] crc_reg;
    assign crc_value = crc_reg;
    always @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) crc_reg <= '0;
        else if (crc_clr) crc_reg <= 16'hffff;
        else if (crc_en) crc_reg <= crc_step(crc_reg, crc_data);
    end

    // Scoreboard.
    typedef struct {
        logic       ok;
        logic [7:0] err;
        int         t0;
    } res_t;

    res_t exp_res[$];
    logic [7:0] exp_data[$];
    int model_err = 0;
    int n_en = 0;
    int n_clr = 0;
    int done_cnt = 0;
    int last_done = 0;
    int rises[$];
    logic busy_prev = 1'b0;
    int low_pct = 0;

    task automatic push_run(input int t0);
        res_t r;
        for (int k = 0; k < N; k++) exp_data.push_back(mem[k]);
        r.ok = (model_crc() == crc_ref);
        if (!r.ok) model_err++;
        r.err = (model_err > 255) ? 8'd255 : 8'(model_err);
        r.t0 = t0;
        exp_res.push_back(r);
    endtask

    initial begin
        res_t r;
        forever begin
            @(negedge clk50m);
            if (rst_n) begin
                if (busy && !busy_prev) rises.push_back(cyc);
                busy_prev = busy;
                if (crc_clr) n_clr++;
                if (crc_en) begin
                    n_en++;
                    if (exp_data.size() == 0) check("unexpected crc_en", 1, 0);
                    else check("crc_data", crc_data, exp_data.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    last_done = cyc;
                    if (exp_res.size() == 0) begin
                        check("unexpected done", 1, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("pass", pass, r.ok);
                        check("fail", fail, !r.ok);
                        check("err_cnt", err_cnt, r.err);
                        check("crc_en count", n_en, N);
                        check("crc_clr count", n_clr, 1);
                        if (r.t0 >= 0) check("done latency", cyc - r.t0, LAT);
                    end
                    n_en = 0;
                    n_clr = 0;
                end
            end else begin
                busy_prev = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk50m);
            #1;
            mem_gnt = ($urandom_range(0, 99) >= low_pct);
        end
    end

    task tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic start_run(input bit timed);
        start = 1'b1;
        push_run(timed ? cyc : -1);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int i;
        n0 = done_cnt;
        i = 0;
        while (done_cnt == n0 && i < budget) begin
            tick();
            i++;
        end
        check("run completes in budget", done_cnt != n0, 1);
    endtask

    logic sat_fin = 1'b0;

    initial begin
        int w;
        tick();
        s_rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 257; i++) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            w = 0;
            while (!s_done && w < 60) begin
                tick();
                w++;
            end
            check("sat run done", s_done, 1);
            if (i == 254) check("err_cnt 254", s_err, 254);
            if (i == 255) check("err_cnt 255", s_err, 255);
            if (i == 257) begin
                check("err_cnt saturated", s_err, 255);
                check("sat fail", s_fail, 1);
            end
            tick();
        end
        sat_fin = 1'b1;
    end

    initial begin
        logic [15:0] good;
        int c0;
        int d1;
        int w;
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
        good = model_crc();
        crc_ref = good;
        repeat (3) tick();
        check("rst busy", busy, 0);
        check("rst mem_req", mem_req, 0);
        check("rst crc_en", crc_en, 0);
        check("rst crc_clr", crc_clr, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst fail", fail, 0);
        check("rst err_cnt", err_cnt, 0);
        check("rst mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Passing run, continuous grant.
        start_run(1);
        wait_done(2000);
        tick();
        check("pass holds", pass, 1);

        // Four failing runs.
        crc_ref = good + 16'd1;
        repeat (4) begin
            start_run(1);
            wait_done(2000);
        end
        check("err_cnt after 4 fails", err_cnt, 4);

        // Interrupted grant.
        crc_ref = good;
        low_pct = 30;
        start_run(0);
        wait_done(6000);
        low_pct = 0;
        tick();

        // Abort at address 500.
        start_run(1);
        w = 0;
        while (mem_addr != 10'd500 && w < 2000) begin
            tick();
            w++;
        end
        check("reached addr 500", mem_addr, 500);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort mem_req", mem_req, 0);
        check("abort crc_en", crc_en, 0);
        exp_data.delete();
        void'(exp_res.pop_back());
        n_en = 0;
        n_clr = 0;
        repeat (1100) tick();
        check("abort pass", pass, 0);
        check("abort fail", fail, 0);
        check("abort err_cnt", err_cnt, 4);
        start_run(1);
        wait_done(2000);

        // Start during busy is dropped.
        tick();
        start_run(1);
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2000);
        repeat (5) tick();
        check("start ignored", busy, 0);

        // Auto-check spacing.
        rises.delete();
        push_run(-1);
        push_run(-1);
        c0 = cyc;
        auto_en = 1'b1;
        w = done_cnt;
        for (int i = 0; i < 9000 && done_cnt < w + 2; i++) tick();
        auto_en = 1'b0;
        check("auto runs", done_cnt - w, 2);
        check("auto rise count", rises.size(), 2);
        if (rises.size() == 2) begin
            check("first auto start", rises[0] - c0, PER + 1);
            check("auto spacing", rises[1] - rises[0], PER);
        end

        // Expiry during a long run restarts right after done.
        repeat (10) tick();
        rises.delete();
        low_pct = 75;
        push_run(-1);
        push_run(-1);
        auto_en = 1'b1;
        wait_done(9000);
        d1 = last_done;
        auto_en = 1'b0;
        wait_done(9000);
        low_pct = 0;
        check("long run rises", rises.size(), 2);
        if (rises.size() == 2) check("restart after done", rises[1], d1 + 1);
        repeat (5) tick();
        check("idle after auto", busy, 0);

        // Asynchronous reset mid-run.
        start_run(1);
        repeat (300) tick();
        rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst mem_req", mem_req, 0);
        check("arst crc_en", crc_en, 0);
        check("arst done", done, 0);
        check("arst pass", pass, 0);
        check("arst fail", fail, 0);
        check("arst err_cnt", err_cnt, 0);
        exp_data.delete();
        exp_res.delete();
        model_err = 0;
        n_en = 0;
        n_clr = 0;
        tick();
        rst_n = 1'b1;
        tick();
        start_run(1);
        wait_done(2000);

        w = 0;
        while (!sat_fin && w < 20000) begin
            tick();
            w++;
        end
        check("saturation test finished", sat_fin, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
